// File: rtl/pipeline_stall_sched.sv
// ============================================================================
// pipeline_stall_sched
//
// Central stall/flush scheduler for the five-stage pipeline. Merges the
// load-use request from hazard detection, taken-branch redirects, data-memory
// wait and the iterative mul/div unit into per-stage stall and flush controls.
// Contains the FSM that launches and waits on the mul/div unit.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> saturating StallCycles / FlushCount performance counters
//   undefined -> no counter registers, both counter outputs tied to 0
//
// Parameters:
//   MD_TIMEOUT  maximum MD_WAIT cycles before the watchdog aborts (>= 2)
//   CNT_W       width of the performance counters
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   LoadUse_D           load-use hazard for the instruction in D
//   BranchTaken_D       branch/jump in D resolved taken
//   MulDivReq_E         mult/div instruction present in E
//   MulDivDone          single-cycle done pulse from the mul/div unit
//   MemReady_M          data memory completes the M access this cycle
//   Stall_F/D/E/M       hold the stage register
//   Flush_D/E/M         insert a bubble into the stage register
//   MulDivStart         one-cycle launch pulse to the mul/div unit
//   State               FSM state: RUN=0, MD_WAIT=1, MD_HOLD=2
//   MdTimeout           sticky watchdog flag
//   StallCycles         cycles with Stall_F=1
//   FlushCount          cycles with Flush_D or Flush_E =1
// ============================================================================
module pipeline_stall_sched #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LoadUse_D,
    input  logic             BranchTaken_D,
    input  logic             MulDivReq_E,
    input  logic             MulDivDone,
    input  logic             MemReady_M,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_M,
    output logic             MulDivStart,
    output logic [1:0]       State,
    output logic             MdTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned WD_W = $clog2(MD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_HOLD = 2'd2
    } state_t;

    state_t          state, stateNext;
    logic [WD_W-1:0] mdCnt, mdCntNext;
    logic            mdTimeoutQ;
    logic            timeoutSet;
    // Set when the watchdog aborts: the aborted instruction is still in E for
    // one more cycle and must not be launched a second time.
    logic            skipStart, skipNext;

    logic mdStall;
    logic stallF, stallD, stallE, stallM;
    logic flushD, flushE, flushM;
    logic startC;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            mdCnt      <= '0;
            mdTimeoutQ <= 1'b0;
            skipStart  <= 1'b0;
        end else begin
            state     <= stateNext;
            mdCnt     <= mdCntNext;
            skipStart <= skipNext;
            if (timeoutSet) begin
                mdTimeoutQ <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and Mealy stall/flush outputs
    // ------------------------------------------------------------------
    always_comb begin
        stateNext  = state;
        mdCntNext  = mdCnt;
        timeoutSet = 1'b0;
        skipNext   = skipStart;
        mdStall    = 1'b0;
        startC     = 1'b0;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;

        unique case (state)
            RUN: begin
                // MulDivDone is ignored here.
                if (MulDivReq_E && MemReady_M && !skipStart) begin
                    startC    = 1'b1;
                    mdStall   = 1'b1;
                    stateNext = MD_WAIT;
                    mdCntNext = '0;
                end
            end
            MD_WAIT: begin
                if (!MulDivDone) begin
                    mdStall   = 1'b1;
                    mdCntNext = mdCnt + WD_W'(1);
                    if (mdCnt == WD_LAST) begin
                        stateNext  = RUN;
                        timeoutSet = 1'b1;
                        skipNext   = 1'b1;
                    end
                end else if (MemReady_M) begin
                    stateNext = RUN;
                end else begin
                    stateNext = MD_HOLD;
                end
            end
            MD_HOLD: begin
                // Result already captured; only the memory wait remains.
                if (MemReady_M) begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase

        if (!MemReady_M) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (mdStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (LoadUse_D) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (BranchTaken_D) begin
            flushD = 1'b1;
        end

        // The aborted instruction leaves E the first cycle E is not held.
        if (state == RUN && !stallE) begin
            skipNext = 1'b0;
        end
    end

    // Controls are forced inactive for as long as reset is held.
    assign Stall_F     = stallF & rst_n;
    assign Stall_D     = stallD & rst_n;
    assign Stall_E     = stallE & rst_n;
    assign Stall_M     = stallM & rst_n;
    assign Flush_D     = flushD & rst_n;
    assign Flush_E     = flushE & rst_n;
    assign Flush_M     = flushM & rst_n;
    assign MulDivStart = startC & rst_n;
    assign State       = state;
    assign MdTimeout   = mdTimeoutQ;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt, flushCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (Stall_F && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if ((Flush_D || Flush_E) && (flushCnt != '1)) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    assign StallCycles = stallCnt;
    assign FlushCount  = flushCnt;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule
